// File: rtl/writeback_buffer_if.sv
// Bus bundle between the MEM stage, the write-back buffer and the register-file write port.
// The slave modport is the buffer's view; the master modport is the surrounding pipeline's view.
interface writeback_buffer_if #(
  parameter int unsigned DATA_WIDTH = 20,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned CNT_WIDTH  = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] instr;
  logic [DATA_WIDTH-1:0] alu_result;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [ADDR_WIDTH-1:0] dest_addr;
  logic                  rf_we;
  logic [ADDR_WIDTH-1:0] rf_addr;
  logic [DATA_WIDTH-1:0] rf_data;
  logic                  rf_ready;
  logic [ADDR_WIDTH-1:0] fwd_query_addr;
  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic [CNT_WIDTH-1:0]  retired_count;

  modport slave (
    input  in_valid, instr, alu_result, mem_data, dest_addr, rf_ready, fwd_query_addr,
    output in_ready, rf_we, rf_addr, rf_data, fwd_hit, fwd_data, retired_count
  );

  modport master (
    output in_valid, instr, alu_result, mem_data, dest_addr, rf_ready, fwd_query_addr,
    input  in_ready, rf_we, rf_addr, rf_data, fwd_hit, fwd_data, retired_count
  );
endinterface

// File: rtl/writeback_buffer.sv
// Write-back stage: selects ALU/load result, queues register writes in a small FIFO so a busy
// register-file port does not stall MEM, forwards from pending writes and counts retirements.
module writeback_buffer #(
  parameter int unsigned                DATA_WIDTH     = 20,
  parameter int unsigned                ADDR_WIDTH     = 4,
  parameter int unsigned                OPCODE_WIDTH   = 4,
  parameter int unsigned                DEPTH          = 2,
  parameter logic [OPCODE_WIDTH-1:0]    STORE_OPCODE   = 4'b1100,
  parameter logic [OPCODE_WIDTH-1:0]    LOAD_OPCODE_A  = 4'b1111,
  parameter logic [OPCODE_WIDTH-1:0]    LOAD_OPCODE_B  = 4'b1101,
  parameter bit                         ZERO_REG_WIRED = 1'b1,
  parameter int unsigned                CNT_WIDTH      = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  writeback_buffer_if.slave   bus
);

  localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned COUNT_W = $clog2(DEPTH + 1);

  logic                  r_we   [DEPTH];
  logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [COUNT_W-1:0]    r_count;
  logic [CNT_WIDTH-1:0]  r_retired;

  logic [OPCODE_WIDTH-1:0] w_opcode;
  logic                    w_is_load;
  logic                    w_new_we;
  logic [DATA_WIDTH-1:0]   w_new_data;
  logic                    w_in_ready;
  logic                    w_push;
  logic                    w_head_valid;
  logic                    w_head_we;
  logic                    w_rf_we;
  logic                    w_pop;
  logic                    w_count_retire;
  logic                    w_fwd_hit;
  logic [DATA_WIDTH-1:0]   w_fwd_data;

  // Decode of the incoming instruction
  assign w_opcode   = bus.instr[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign w_is_load  = (w_opcode == LOAD_OPCODE_A) || (w_opcode == LOAD_OPCODE_B);
  assign w_new_data = w_is_load ? bus.mem_data : bus.alu_result;
  assign w_new_we   = (w_opcode != STORE_OPCODE) &&
                      !(ZERO_REG_WIRED && (bus.dest_addr == '0));

  // Ready depends only on the registered occupancy, so a pop never opens a slot in the same cycle
  assign w_in_ready   = (r_count != COUNT_W'(DEPTH));
  assign w_push       = bus.in_valid && w_in_ready && !flush;
  assign w_head_valid = (r_count != '0);
  assign w_head_we    = r_we[r_rd_ptr];
  assign w_rf_we      = w_head_valid && w_head_we;
  assign w_pop        = w_head_valid && (!w_head_we || bus.rf_ready);
  // During flush only a real register-file write counts as retired
  assign w_count_retire = flush ? (w_rf_we && bus.rf_ready) : w_pop;

  // Youngest matching pending write wins: scan oldest to youngest, later matches override
  always_comb begin
    logic [PTR_W-1:0] idx;
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    idx        = r_rd_ptr;
    for (int k = 0; k < int'(DEPTH); k++) begin
      idx = r_rd_ptr + PTR_W'(k);
      if ((COUNT_W'(k) < r_count) && r_we[idx] && (r_addr[idx] == bus.fwd_query_addr)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_data[idx];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_retired <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_we[i]   <= 1'b0;
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_count_retire) begin
        r_retired <= r_retired + CNT_WIDTH'(1);
      end
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_we[r_wr_ptr]   <= w_new_we;
          r_addr[r_wr_ptr] <= bus.dest_addr;
          r_data[r_wr_ptr] <= w_new_data;
          r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + COUNT_W'(1);
          2'b01:   r_count <= r_count - COUNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.rf_we         = w_rf_we;
  assign bus.rf_addr       = w_head_valid ? r_addr[r_rd_ptr] : '0;
  assign bus.rf_data       = w_head_valid ? r_data[r_rd_ptr] : '0;
  assign bus.fwd_hit       = w_fwd_hit;
  assign bus.fwd_data      = w_fwd_data;
  assign bus.retired_count = r_retired;

endmodule

// File: tb/tb_writeback_buffer.sv
// Directed bench for writeback_buffer: reset, ALU/load/store selection, back-pressure,
// forwarding, zero register, flush and mid-stream reset, with hand-computed expectations.
module tb_writeback_buffer;
  localparam int unsigned DW = 20;
  localparam int unsigned AW = 4;
  localparam int unsigned CW = 32;

  logic clock;
  logic reset;
  logic flush;

  int n_cmp;
  int n_bad;

  writeback_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  writeback_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after the rising edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] ins, input logic [DW-1:0] alu,
                       input logic [DW-1:0] mem, input logic [AW-1:0] dst);
    bus.in_valid   = v;
    bus.instr      = ins;
    bus.alu_result = alu;
    bus.mem_data   = mem;
    bus.dest_addr  = dst;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    flush = 1'b0;
    bus.rf_ready       = 1'b0;
    bus.fwd_query_addr = '0;
    drive(1'b1, 20'h00005, 20'h00ABC, 20'h0, 4'd3);

    // 1: reset held two cycles with in_valid high
    step();
    step();
    reset = 1'b0;
    drive(1'b0, 20'h0, 20'h0, 20'h0, 4'd0);
    #1;
    check("rst_rf_we",    32'(bus.rf_we), 32'd0);
    check("rst_retired",  bus.retired_count, 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_rf_data",  32'(bus.rf_data), 32'd0);
    check("rst_fwd_hit",  32'(bus.fwd_hit), 32'd0);

    // 2: ALU op
    bus.rf_ready = 1'b1;
    drive(1'b1, 20'h00005, 20'h00ABC, 20'h0FFFF, 4'd3);
    step();
    drive(1'b0, 20'h0, 20'h0, 20'h0, 4'd0);
    bus.fwd_query_addr = 4'd3;
    #1;
    check("alu_rf_we",   32'(bus.rf_we), 32'd1);
    check("alu_rf_addr", 32'(bus.rf_addr), 32'd3);
    check("alu_rf_data", 32'(bus.rf_data), 32'h00ABC);
    check("alu_fwd_hit", 32'(bus.fwd_hit), 32'd1);
    check("alu_fwd_dat", 32'(bus.fwd_data), 32'h00ABC);
    check("alu_ret_pre", bus.retired_count, 32'd0);
    step();
    check("alu_retired", bus.retired_count, 32'd1);
    check("alu_empty",   32'(bus.rf_we), 32'd0);

    // 3: load (opcode B), store, load (opcode A)
    drive(1'b1, 20'hD0000, 20'h55555, 20'h12345, 4'd7);
    step();
    drive(1'b0, 20'h0, 20'h0, 20'h0, 4'd0);
    #1;
    check("ldb_rf_we",   32'(bus.rf_we), 32'd1);
    check("ldb_rf_addr", 32'(bus.rf_addr), 32'd7);
    check("ldb_rf_data", 32'(bus.rf_data), 32'h12345);
    step();
    check("ldb_retired", bus.retired_count, 32'd2);
    drive(1'b1, 20'hC0000, 20'h00777, 20'h0, 4'd5);
    bus.fwd_query_addr = 4'd5;
    step();
    drive(1'b0, 20'h0, 20'h0, 20'h0, 4'd0);
    #1;
    check("st_rf_we",    32'(bus.rf_we), 32'd0);
    check("st_fwd_hit",  32'(bus.fwd_hit), 32'd0);
    step();
    check("st_retired",  bus.retired_count, 32'd3);
    check("st_rf_we2",   32'(bus.rf_we), 32'd0);
    drive(1'b1, 20'hF0000, 20'h11111, 20'hAAAAA, 4'd2);
    step();
    drive(1'b0, 20'h0, 20'h0, 20'h0, 4'd0);
    #1;
    check("lda_rf_data", 32'(bus.rf_data), 32'hAAAAA);
    step();
    check("lda_retired", bus.retired_count, 32'd4);

    // 4: back-pressure, forwarding of youngest, full blocks push even with a pop
    bus.rf_ready = 1'b0;
    bus.fwd_query_addr = 4'd1;
    drive(1'b1, 20'h00001, 20'h00001, 20'h0, 4'd1);
    step();
    check("bp_ready1",   32'(bus.in_ready), 32'd1);
    drive(1'b1, 20'h00001, 20'h00002, 20'h0, 4'd1);
    step();
    drive(1'b0, 20'h0, 20'h0, 20'h0, 4'd0);
    #1;
    check("bp_ready0",   32'(bus.in_ready), 32'd0);
    check("bp_head",     32'(bus.rf_data), 32'd1);
    check("bp_fwd_hit",  32'(bus.fwd_hit), 32'd1);
    check("bp_fwd_dat",  32'(bus.fwd_data), 32'd2);
    drive(1'b1, 20'h00001, 20'h00003, 20'h0, 4'd9);
    bus.rf_ready = 1'b1;
    bus.fwd_query_addr = 4'd9;
    step();
    drive(1'b0, 20'h0, 20'h0, 20'h0, 4'd0);
    #1;
    check("bp_blocked",  32'(bus.fwd_hit), 32'd0);
    check("bp_wr2_addr", 32'(bus.rf_addr), 32'd1);
    check("bp_wr2_data", 32'(bus.rf_data), 32'd2);
    check("bp_ret5",     bus.retired_count, 32'd5);
    step();
    check("bp_ret6",     bus.retired_count, 32'd6);
    check("bp_empty",    32'(bus.rf_we), 32'd0);

    // Push and pop in the same cycle keeps order
    drive(1'b1, 20'h00001, 20'h00100, 20'h0, 4'd4);
    step();
    check("pp_head1",    32'(bus.rf_data), 32'h00100);
    drive(1'b1, 20'h00001, 20'h00200, 20'h0, 4'd6);
    step();
    drive(1'b0, 20'h0, 20'h0, 20'h0, 4'd0);
    #1;
    check("pp_head2",    32'(bus.rf_data), 32'h00200);
    check("pp_addr2",    32'(bus.rf_addr), 32'd6);
    check("pp_ret7",     bus.retired_count, 32'd7);
    step();
    check("pp_ret8",     bus.retired_count, 32'd8);

    // 5: zero register write is suppressed and retires without rf_ready
    bus.rf_ready = 1'b0;
    bus.fwd_query_addr = 4'd0;
    drive(1'b1, 20'h00001, 20'h00003, 20'h0, 4'd0);
    step();
    drive(1'b0, 20'h0, 20'h0, 20'h0, 4'd0);
    #1;
    check("z_rf_we",     32'(bus.rf_we), 32'd0);
    check("z_fwd_hit",   32'(bus.fwd_hit), 32'd0);
    check("z_rf_data",   32'(bus.rf_data), 32'd3);
    step();
    check("z_retired",   bus.retired_count, 32'd9);

    // 6a: flush of a full FIFO with a concurrent input
    drive(1'b1, 20'h00001, 20'h0000A, 20'h0, 4'd5);
    step();
    drive(1'b1, 20'h00001, 20'h0000B, 20'h0, 4'd6);
    step();
    check("fl_full",     32'(bus.in_ready), 32'd0);
    drive(1'b1, 20'h00001, 20'h0000C, 20'h0, 4'd8);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 20'h0, 20'h0, 20'h0, 4'd0);
    bus.fwd_query_addr = 4'd8;
    #1;
    check("fl_ready",    32'(bus.in_ready), 32'd1);
    check("fl_rf_we",    32'(bus.rf_we), 32'd0);
    check("fl_drop_in",  32'(bus.fwd_hit), 32'd0);
    check("fl_retired",  bus.retired_count, 32'd9);

    // 6b: a write accepted during the flush cycle still counts
    drive(1'b1, 20'h00001, 20'h0000D, 20'h0, 4'd5);
    step();
    drive(1'b0, 20'h0, 20'h0, 20'h0, 4'd0);
    bus.rf_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.rf_ready = 1'b0;
    #1;
    check("flp_retired", bus.retired_count, 32'd10);
    check("flp_empty",   32'(bus.rf_we), 32'd0);

    // 6c: reset mid-stream with a full FIFO
    drive(1'b1, 20'h00001, 20'h0000E, 20'h0, 4'd5);
    step();
    step();
    drive(1'b0, 20'h0, 20'h0, 20'h0, 4'd0);
    bus.fwd_query_addr = 4'd5;
    #1;
    check("rs_full",     32'(bus.in_ready), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("rs_retired",  bus.retired_count, 32'd0);
    check("rs_ready",    32'(bus.in_ready), 32'd1);
    check("rs_rf_we",    32'(bus.rf_we), 32'd0);
    check("rs_fwd_hit",  32'(bus.fwd_hit), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
